// File: rtl/ddr_gearbox_serializer.sv
// ddr_gearbox_serializer
//
// Multi-channel DDR serializer in the serial clock domain. One parallel word
// per channel is accepted through a valid/ready handshake into a one-deep
// holding register. It is then transmitted two bits per serial clock: one bit
// for the rising-edge half and one for the falling-edge half of the pad ODDR.
// All channels share one beat counter and move in lock-step. When a word
// boundary finds the holding register empty, IDLE_WORD is sent on every
// channel and a sticky underflow flag is raised.
//
// Ports:
//   i_serclk         serial clock, all logic on its rising edge
//   i_rst            asynchronous reset, active-high
//   i_data           NUM_CH words, channel c at [c*DATA_W +: DATA_W]
//   i_valid          i_data is valid
//   o_ready          i_data is accepted this cycle (registers only)
//   i_clr_underflow  synchronous clear of o_underflow
//   o_ser_re         rising-edge bit per channel, registered
//   o_ser_fe         falling-edge bit per channel, registered
//   o_frame          high while beat 0 of a word is on the pins
//   o_underflow      sticky: a word boundary found the hold register empty
module ddr_gearbox_serializer #(
    parameter int                DATA_W    = 10,
    parameter int                NUM_CH    = 3,
    parameter bit                MSB_FIRST = 1'b0,
    parameter logic [DATA_W-1:0] IDLE_WORD = 10'b1101010100
) (
    input  logic                     i_serclk,
    input  logic                     i_rst,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_clr_underflow,
    output logic [NUM_CH-1:0]        o_ser_re,
    output logic [NUM_CH-1:0]        o_ser_fe,
    output logic                     o_frame,
    output logic                     o_underflow
);

    localparam int               BEATS     = DATA_W / 2;
    localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int               WORDS_W   = NUM_CH * DATA_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (((DATA_W % 2) != 0) || (DATA_W < 4)) begin : g_bad_data_w
        $error("ddr_gearbox_serializer: DATA_W must be even and >= 4");
    end

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hold_valid_q, hold_valid_d;
    logic [WORDS_W-1:0] hold_q, hold_d;
    logic [WORDS_W-1:0] shift_q, shift_d;
    logic [NUM_CH-1:0]  ser_re_q, ser_re_d;
    logic [NUM_CH-1:0]  ser_fe_q, ser_fe_d;
    logic               frame_q, frame_d;
    logic               underflow_q, underflow_d;

    logic load;
    logic xfer;

    // The load cycle is the last beat of the current word.
    assign load    = (cnt_q == LAST_BEAT);
    // The hold slot frees up on the load cycle, so a new word can be taken
    // in the same cycle the held one moves into the shift register.
    assign o_ready = ~hold_valid_q | load;
    assign xfer    = i_valid & o_ready;

    always_comb begin : p_next_state
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d        = load ? '0 : cnt_q + 1'b1;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        underflow_d  = underflow_q;
        frame_d      = (cnt_q == '0);

        if (i_clr_underflow) begin
            underflow_d = 1'b0;
        end

        if (xfer) begin
            hold_d = i_data;
        end

        if (load) begin
            if (hold_valid_q) begin
                shift_d = hold_q;
            end else begin
                // An empty slot at a boundary sends idle. A word arriving in
                // this same cycle only fills hold and waits for the next
                // boundary. The set overrides any clear in this cycle.
                shift_d     = {NUM_CH{IDLE_WORD}};
                underflow_d = 1'b1;
            end
            hold_valid_d = xfer;
        end else if (xfer) begin
            hold_valid_d = 1'b1;
        end
    end

    // Beat k of each channel's shift word is selected by the counter value;
    // the loop unrolls to constant bit indices.
    always_comb begin : p_beat_select
        ser_re_d = '0;
        ser_fe_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < BEATS; b++) begin
                if (cnt_q == CNT_W'(b)) begin
                    if (MSB_FIRST) begin
                        ser_re_d[c] = shift_q[c*DATA_W + DATA_W - 1 - 2*b];
                        ser_fe_d[c] = shift_q[c*DATA_W + DATA_W - 2 - 2*b];
                    end else begin
                        ser_re_d[c] = shift_q[c*DATA_W + 2*b];
                        ser_fe_d[c] = shift_q[c*DATA_W + 2*b + 1];
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge i_serclk or posedge i_rst) begin : p_state_regs
        if (i_rst) begin
            cnt_q        <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            ser_re_q     <= '0;
            ser_fe_q     <= '0;
            frame_q      <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            ser_re_q     <= ser_re_d;
            ser_fe_q     <= ser_fe_d;
            frame_q      <= frame_d;
            underflow_q  <= underflow_d;
        end
    end

    // NOTE: the hold data carries no reset; it is only ever consumed when
    // hold_valid_q is set, and hold_valid_q is reset.
    always_ff @(posedge i_serclk) begin : p_hold_data
        hold_q <= hold_d;
    end

    assign o_ser_re    = ser_re_q;
    assign o_ser_fe    = ser_fe_q;
    assign o_frame     = frame_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_ddr_gearbox_serializer.sv
// Directed testbench for ddr_gearbox_serializer.
// Instance A: default parameters (10-bit, 3 channels, LSB first).
// Instance B: 8-bit, 2 channels, MSB first, idle word 8'h3C.
// Cycle n means the n-th clock period after reset release (counter = n mod BEATS).
module tb_ddr_gearbox_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic        rst_a   = 1'b1;
    logic [29:0] data_a  = '0;
    logic        valid_a = 1'b0;
    logic        clr_a   = 1'b0;
    logic        ready_a;
    logic [2:0]  re_a, fe_a;
    logic        frame_a, uf_a;

    // Instance B signals
    logic        rst_b   = 1'b1;
    logic [15:0] data_b  = '0;
    logic        valid_b = 1'b0;
    logic        clr_b   = 1'b0;
    logic        ready_b;
    logic [1:0]  re_b, fe_b;
    logic        frame_b, uf_b;

    int checks = 0;
    int errors = 0;

    // Beat k of a uniform word lives in bit k of these 5-bit patterns.
    localparam logic [4:0] IDLE_RE = 5'b11110;  // 10'b1101010100, LSB first
    localparam logic [4:0] IDLE_FE = 5'b10000;
    localparam logic [9:0] WORD_A  = 10'b0000011111;
    localparam logic [4:0] A_RE    = 5'b00111;
    localparam logic [4:0] A_FE    = 5'b00011;
    localparam logic [9:0] WORD_B  = 10'b1100110011;
    localparam logic [4:0] B_RE    = 5'b10101;
    localparam logic [4:0] B_FE    = 5'b10101;
    localparam logic [9:0] WORD_D  = 10'b1010101010;
    localparam logic [4:0] D_RE    = 5'b00000;
    localparam logic [4:0] D_FE    = 5'b11111;

    logic [29:0] exp_q [$];
    logic [9:0]  rx [3];

    ddr_gearbox_serializer u_dut_a (
        .i_serclk        (clk),
        .i_rst           (rst_a),
        .i_data          (data_a),
        .i_valid         (valid_a),
        .o_ready         (ready_a),
        .i_clr_underflow (clr_a),
        .o_ser_re        (re_a),
        .o_ser_fe        (fe_a),
        .o_frame         (frame_a),
        .o_underflow     (uf_a)
    );

    ddr_gearbox_serializer #(
        .DATA_W    (8),
        .NUM_CH    (2),
        .MSB_FIRST (1'b1),
        .IDLE_WORD (8'h3C)
    ) u_dut_b (
        .i_serclk        (clk),
        .i_rst           (rst_b),
        .i_data          (data_b),
        .i_valid         (valid_b),
        .o_ready         (ready_b),
        .i_clr_underflow (clr_b),
        .o_ser_re        (re_b),
        .o_ser_fe        (fe_b),
        .o_frame         (frame_b),
        .o_underflow     (uf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] rep3(input logic [4:0] b);
        logic [14:0] r;
        for (int k = 0; k < 5; k++) r[3*k +: 3] = {3{b[k]}};
        return r;
    endfunction

    function automatic logic [29:0] stream_word(input int n);
        return {10'(n + 682), 10'(n + 341), 10'(n)};
    endfunction

    task automatic chk_a(input string tag, input logic [2:0] re, input logic [2:0] fe, input logic frame);
        check($sformatf("%s_re", tag), 32'(re_a), 32'(re));
        check($sformatf("%s_fe", tag), 32'(fe_a), 32'(fe));
        check($sformatf("%s_frame", tag), 32'(frame_a), 32'(frame));
    endtask

    // Checks five consecutive beats on instance A; ends on the last beat cycle.
    task automatic word_a(input string tag, input logic [14:0] re_v, input logic [14:0] fe_v);
        for (int k = 0; k < 5; k++) begin
            chk_a($sformatf("%s_b%0d", tag, k), re_v[3*k +: 3], fe_v[3*k +: 3], k == 0);
            if (k < 4) step();
        end
    endtask

    // Reset instance A over one clock edge; returns in cycle 0.
    task automatic reset_a(input string tag);
        rst_a   = 1'b1;
        valid_a = 1'b0;
        clr_a   = 1'b0;
        data_a  = '0;
        #1;
        chk_a($sformatf("%s_rst", tag), 3'b000, 3'b000, 1'b0);
        check($sformatf("%s_rst_uf", tag), 32'(uf_a), 32'd0);
        check($sformatf("%s_rst_ready", tag), 32'(ready_a), 32'd1);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
    endtask

    // Timeline with no input traffic, starting in cycle 0; ends in cycle 11.
    task automatic idle_timeline_a(input string tag);
        check($sformatf("%s_c0_frame", tag), 32'(frame_a), 32'd0);
        check($sformatf("%s_c0_ready", tag), 32'(ready_a), 32'd1);
        step();
        chk_a($sformatf("%s_c1", tag), 3'b000, 3'b000, 1'b1);
        step(); step(); step();
        check($sformatf("%s_c4_uf", tag), 32'(uf_a), 32'd0);
        step();
        chk_a($sformatf("%s_c5", tag), 3'b000, 3'b000, 1'b0);
        check($sformatf("%s_c5_uf", tag), 32'(uf_a), 32'd1);
        step();
        word_a($sformatf("%s_idle", tag), rep3(IDLE_RE), rep3(IDLE_FE));
        step();
        chk_a($sformatf("%s_c11", tag), 3'b000, 3'b000, 1'b1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  sent;
        int  rcv;
        int  beat;
        bit  in_word;
        bit  xfer;
        bit  uf_seen;
        logic [7:0] b_re_v;
        logic [7:0] b_fe_v;

        // Scenario 1: idle after reset.
        reset_a("t1");
        idle_timeline_a("t1");

        // Scenario 2: single word accepted before the first load.
        reset_a("t2");
        data_a  = {10'b0101010101, 10'b1111111111, 10'b1000000001};
        valid_a = 1'b1;
        check("t2_c0_ready", 32'(ready_a), 32'd1);
        step();
        valid_a = 1'b0;
        check("t2_c1_ready", 32'(ready_a), 32'd0);
        step(); step(); step(); step();
        check("t2_c5_uf", 32'(uf_a), 32'd0);
        step();
        word_a("t2_word", {3'b110, 3'b110, 3'b110, 3'b110, 3'b111},
                          {3'b011, 3'b010, 3'b010, 3'b010, 3'b010});
        check("t2_c10_uf", 32'(uf_a), 32'd1);
        step();
        chk_a("t2_c11_idle", 3'b000, 3'b000, 1'b1);
        check("t2_c11_uf", 32'(uf_a), 32'd1);

        // Scenario 3: continuous stream from cycle 11, after clearing underflow.
        sent    = 0;
        rcv     = 0;
        beat    = 0;
        in_word = 1'b0;
        uf_seen = 1'b0;
        data_a  = stream_word(0);
        valid_a = 1'b1;
        clr_a   = 1'b1;
        for (int cyc = 0; cyc < 1300 && rcv < 200; cyc++) begin
            xfer = valid_a && ready_a;
            if (xfer) begin
                exp_q.push_back(data_a);
                sent++;
            end
            step();
            clr_a = 1'b0;
            if (xfer) begin
                if (sent < 200) data_a = stream_word(sent);
                else valid_a = 1'b0;
            end
            if (frame_a) begin
                beat    = 0;
                in_word = 1'b1;
                if (rcv < 199 && uf_a) uf_seen = 1'b1;
            end
            if (in_word) begin
                for (int c = 0; c < 3; c++) begin
                    rx[c][2*beat]     = re_a[c];
                    rx[c][2*beat + 1] = fe_a[c];
                end
                beat++;
                if (beat == 5) begin
                    in_word = 1'b0;
                    check($sformatf("t3_queue_nonempty%0d", rcv), 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0)
                        check($sformatf("t3_word%0d", rcv), 32'({rx[2], rx[1], rx[0]}),
                              32'(exp_q.pop_front()));
                    rcv++;
                end
            end
        end
        check("t3_words_received", 32'(rcv), 32'd200);
        check("t3_uf_stayed_low", 32'(uf_seen), 32'd0);

        // Scenario 5: backpressure and underflow clear/set priority.
        reset_a("t5");
        data_a  = {3{WORD_A}};
        valid_a = 1'b1;
        check("t5_c0_ready", 32'(ready_a), 32'd1);
        step();
        data_a = '0;  // must not be taken while hold is full
        check("t5_c1_ready", 32'(ready_a), 32'd0);
        step();
        check("t5_c2_ready", 32'(ready_a), 32'd0);
        step();
        check("t5_c3_ready", 32'(ready_a), 32'd0);
        step();
        check("t5_c4_ready", 32'(ready_a), 32'd1);
        data_a = {3{WORD_B}};
        step();
        valid_a = 1'b0;
        check("t5_c5_ready", 32'(ready_a), 32'd0);
        step();
        word_a("t5_a", rep3(A_RE), rep3(A_FE));
        step();
        word_a("t5_b", rep3(B_RE), rep3(B_FE));
        step();
        chk_a("t5_c16_idle", 3'b000, 3'b000, 1'b1);
        check("t5_c16_uf", 32'(uf_a), 32'd1);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        check("t5_c17_uf_cleared", 32'(uf_a), 32'd0);
        step(); step();
        check("t5_c19_uf", 32'(uf_a), 32'd0);
        clr_a = 1'b1;  // load cycle with empty hold: set wins
        step();
        clr_a = 1'b0;
        check("t5_c20_uf_set_wins", 32'(uf_a), 32'd1);

        // Scenario 6: reset during beat 2 with a word buffered.
        reset_a("t6");
        data_a  = {3{WORD_D}};
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        step(); step(); step(); step();
        check("t6_c5_ready", 32'(ready_a), 32'd1);
        data_a  = {3{10'b1111111111}};
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        check("t6_c6_ready", 32'(ready_a), 32'd0);
        chk_a("t6_c6_b0", rep3(D_RE)[2:0], rep3(D_FE)[2:0], 1'b1);
        step();
        chk_a("t6_c7_b1", 3'b000, 3'b111, 1'b0);
        step();
        chk_a("t6_c8_b2", 3'b000, 3'b111, 1'b0);
        rst_a = 1'b1;
        #1;
        chk_a("t6_midrst", 3'b000, 3'b000, 1'b0);
        check("t6_midrst_ready", 32'(ready_a), 32'd1);
        check("t6_midrst_uf", 32'(uf_a), 32'd0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        idle_timeline_a("t6_after");

        // Scenario 4: DATA_W=8, MSB first, word 8'hA5 on ch0 and 8'hFF on ch1.
        // Beat k at [2k +: 2] = {ch1, ch0}.
        b_re_v = {2'b10, 2'b10, 2'b11, 2'b11};
        b_fe_v = {2'b11, 2'b11, 2'b10, 2'b10};
        rst_b = 1'b1;
        #1;
        check("t4_rst_re", 32'(re_b), 32'd0);
        check("t4_rst_frame", 32'(frame_b), 32'd0);
        @(posedge clk);
        #1;
        rst_b   = 1'b0;
        data_b  = {8'hFF, 8'hA5};
        valid_b = 1'b1;
        check("t4_c0_ready", 32'(ready_b), 32'd1);
        step();
        valid_b = 1'b0;
        step(); step(); step(); step();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4_b%0d_re", k), 32'(re_b), 32'(b_re_v[2*k +: 2]));
            check($sformatf("t4_b%0d_fe", k), 32'(fe_b), 32'(b_fe_v[2*k +: 2]));
            check($sformatf("t4_b%0d_frame", k), 32'(frame_b), 32'(k == 0));
            if (k == 2) check("t4_c7_uf", 32'(uf_b), 32'd0);
            if (k == 3) check("t4_c8_uf", 32'(uf_b), 32'd1);
            step();
        end
        check("t4_c9_idle_re", 32'(re_b), 32'd0);
        check("t4_c9_idle_fe", 32'(fe_b), 32'd0);
        check("t4_c9_frame", 32'(frame_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
